// File: rtl/sh_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sh_sync_pkg
// Description : Shared types and defaults for the sample-and-hold sync generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sh_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_GEN     = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_TX      = 3'd5
    } state_t;

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] c_ERR_JITTER  = 2'd2;

    localparam int c_DEF_CNT_W      = 14;
    localparam int c_DEF_PRE_LOG2   = 3;
    localparam int c_DEF_PKT_LEN    = 24;
    localparam int c_DEF_TX_PULSES  = 32;
    localparam int c_DEF_TX_PERIOD  = 10000;
    localparam int c_DEF_TIMEOUT    = 14000;
    localparam int c_DEF_JIT_TOL    = 64;
    localparam int c_DEF_MIN_PERIOD = 2;

endpackage
`default_nettype wire

// File: rtl/sh_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : sh_pulse_timer
// Description : Loadable period counter: half-period first strobe, then periodic.
// Revision    : 1.0 - initial release
// ============================================================================
module sh_pulse_timer #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_zero,
    output logic             o_final
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_nstrb;

    // Outputs are independent of i_run so the controller can gate them without a loop.
    assign o_zero  = (r_cnt == '0);
    assign o_final = (r_nstrb == (i_limit - c_ONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_nstrb  <= '0;
        end else if (i_load) begin
            r_period <= i_period;
            r_cnt    <= i_period >> 1;
            r_nstrb  <= '0;
        end else if (i_run) begin
            if (o_zero) begin
                r_cnt   <= r_period - c_ONE;
                r_nstrb <= r_nstrb + c_ONE;
            end else begin
                r_cnt   <= r_cnt - c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sh_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : sh_sync_gen
// Description : Preamble bit-period recovery and sh_en strobe generation (RX/TX).
// Revision    : 1.0 - initial release
// ============================================================================
module sh_sync_gen
    import sh_sync_pkg::*;
#(
    parameter int CNT_W      = c_DEF_CNT_W,
    parameter int PRE_LOG2   = c_DEF_PRE_LOG2,
    parameter int PKT_LEN    = c_DEF_PKT_LEN,
    parameter int TX_PULSES  = c_DEF_TX_PULSES,
    parameter int TX_PERIOD  = c_DEF_TX_PERIOD,
    parameter int TIMEOUT    = c_DEF_TIMEOUT,
    parameter int JIT_TOL    = c_DEF_JIT_TOL,
    parameter int MIN_PERIOD = c_DEF_MIN_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rfin,
    input  logic             rx_mode,
    input  logic             tx_rdy,
    input  logic             ext_rx_en,
    input  logic [CNT_W-1:0] ext_rx_period,
    input  logic             ext_tx_en,
    input  logic [CNT_W-1:0] ext_tx_period,
    output logic             sh_en,
    output logic             fsm_rst,
    output logic             sh_en_done,
    output logic             locked,
    output logic [CNT_W-1:0] period_out,
    output logic             err_timeout,
    output logic             err_jitter
);

    localparam int              c_SUM_W     = CNT_W + PRE_LOG2;
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN      = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] c_TOL      = CNT_W'(JIT_TOL);
    localparam logic [CNT_W-1:0] c_TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TXP      = CNT_W'(TX_PERIOD);
    localparam logic [CNT_W-1:0] c_RX_LIM   = CNT_W'(PKT_LEN);
    localparam logic [CNT_W-1:0] c_TX_LIM   = CNT_W'(TX_PULSES);
    localparam logic [PRE_LOG2:0] c_N_ONE   = (PRE_LOG2+1)'(1);
    localparam logic [PRE_LOG2:0] c_N_LAST  = (PRE_LOG2+1)'(2**PRE_LOG2 - 1);

    state_t              r_state, w_next;
    logic                r_rf_s1, r_rf_s2, r_rf_s3, r_rf_edge;
    logic                r_tx_d, r_tx_edge;
    logic [CNT_W-1:0]    r_ivl;
    logic [CNT_W-1:0]    r_ref;
    logic [c_SUM_W-1:0]  r_sum;
    logic [PRE_LOG2:0]   r_nacc;
    logic [CNT_W-1:0]    r_period_out;

    logic [CNT_W-1:0]    w_diff, w_p_raw, w_p, w_q_raw, w_q;
    logic                w_jit_bad, w_complete, w_timeout;
    logic                w_restart, w_acc, w_clear, w_load_rx, w_load_tx, w_run;
    logic [1:0]          w_err;
    logic                w_tmr_zero, w_tmr_final;

    // Synchroniser plus registered edge detect: flag appears 3 cycles after rfin rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_s1   <= 1'b0;
            r_rf_s2   <= 1'b0;
            r_rf_s3   <= 1'b0;
            r_rf_edge <= 1'b0;
            r_tx_d    <= 1'b0;
            r_tx_edge <= 1'b0;
        end else begin
            r_rf_s1   <= rfin;
            r_rf_s2   <= r_rf_s1;
            r_rf_s3   <= r_rf_s2;
            r_rf_edge <= r_rf_s2 & ~r_rf_s3;
            r_tx_d    <= tx_rdy;
            r_tx_edge <= tx_rdy & ~r_tx_d;
        end
    end

    assign w_diff     = (r_ivl >= r_ref) ? (r_ivl - r_ref) : (r_ref - r_ivl);
    assign w_jit_bad  = (r_nacc != '0) && (w_diff > c_TOL);
    assign w_complete = r_rf_edge && !w_jit_bad && (r_nacc == c_N_LAST);
    assign w_timeout  = (r_ivl == c_TMO);

    assign w_p_raw = ext_rx_en ? ext_rx_period : r_sum[c_SUM_W-1:PRE_LOG2];
    assign w_p     = (w_p_raw < c_MIN) ? c_MIN : w_p_raw;
    assign w_q_raw = ext_tx_en ? ext_tx_period : c_TXP;
    assign w_q     = (w_q_raw < c_MIN) ? c_MIN : w_q_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_restart  = 1'b0;
        w_acc      = 1'b0;
        w_clear    = 1'b0;
        w_load_rx  = 1'b0;
        w_load_tx  = 1'b0;
        w_run      = 1'b0;
        w_err      = c_ERR_NONE;
        fsm_rst    = 1'b0;
        sh_en_done = 1'b1;
        locked     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rx_mode) begin
                    w_next = ST_WAIT_TX;
                end else if (r_rf_edge) begin
                    w_next    = ST_COLLECT;
                    w_restart = 1'b1;
                    w_clear   = 1'b1;
                    fsm_rst   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (w_complete) begin
                    w_acc   = 1'b1;
                    fsm_rst = 1'b1;
                    w_next  = ST_COMPUTE;
                end else if (w_timeout) begin
                    w_err   = c_ERR_TIMEOUT;
                    fsm_rst = 1'b1;
                    w_next  = ST_IDLE;
                end else if (!rx_mode) begin
                    w_next = ST_WAIT_TX;
                end else if (r_rf_edge) begin
                    // A rejected edge restarts the preamble as its new first edge.
                    w_restart = 1'b1;
                    if (w_jit_bad) begin
                        w_err   = c_ERR_JITTER;
                        w_clear = 1'b1;
                    end else begin
                        w_acc   = 1'b1;
                        fsm_rst = 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                locked    = 1'b1;
                w_load_rx = 1'b1;
                w_next    = ST_GEN;
            end
            ST_GEN: begin
                locked = 1'b1;
                if (!rx_mode) begin
                    w_next = ST_WAIT_TX;
                end else begin
                    w_run = 1'b1;
                    if (w_tmr_zero && w_tmr_final) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_TX: begin
                sh_en_done = 1'b0;
                if (rx_mode) begin
                    w_next = ST_IDLE;
                end else if (r_tx_edge) begin
                    w_load_tx = 1'b1;
                    w_next    = ST_TX;
                end
            end
            ST_TX: begin
                sh_en_done = 1'b0;
                if (rx_mode) begin
                    w_next = ST_IDLE;
                end else begin
                    w_run = 1'b1;
                    if (w_tmr_zero && w_tmr_final) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // r_ivl counts cycles since the last edge, so it holds the interval itself on the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ivl        <= '0;
            r_ref        <= '0;
            r_sum        <= '0;
            r_nacc       <= '0;
            r_period_out <= '0;
        end else begin
            if (w_restart) begin
                r_ivl <= c_ONE;
            end else if (r_state == ST_COLLECT) begin
                r_ivl <= r_ivl + c_ONE;
            end
            if (w_clear) begin
                r_sum  <= '0;
                r_nacc <= '0;
            end else if (w_acc) begin
                if (r_nacc == '0) begin
                    r_ref <= r_ivl;
                end
                r_sum  <= r_sum + {{PRE_LOG2{1'b0}}, r_ivl};
                r_nacc <= r_nacc + c_N_ONE;
            end
            if (w_load_rx) begin
                r_period_out <= w_p;
            end
        end
    end

    sh_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load_rx | w_load_tx),
        .i_run    (w_run),
        .i_period (w_load_tx ? w_q : w_p),
        .i_limit  ((r_state == ST_TX) ? c_TX_LIM : c_RX_LIM),
        .o_zero   (w_tmr_zero),
        .o_final  (w_tmr_final)
    );

    assign sh_en       = w_run & w_tmr_zero;
    assign period_out  = r_period_out;
    assign err_timeout = (w_err == c_ERR_TIMEOUT);
    assign err_jitter  = (w_err == c_ERR_JITTER);

endmodule
`default_nettype wire

// File: tb/tb_sh_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sh_sync_gen
// Description : Directed self-checking bench for sh_sync_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sh_sync_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        rfin;
    logic        rx_mode;
    logic        tx_rdy;
    logic        ext_rx_en;
    logic [13:0] ext_rx_period;
    logic        ext_tx_en;
    logic [13:0] ext_tx_period;
    logic        sh_en, fsm_rst, sh_en_done, locked, err_timeout, err_jitter;
    logic [13:0] period_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int sh_q[$];
    int tmo_q[$];
    int jit_q[$];
    int fsm_cnt = 0;
    int consec  = 0;
    logic prev_sh = 1'b0;

    sh_sync_gen dut (
        .clk           (clk),
        .rst           (rst),
        .rfin          (rfin),
        .rx_mode       (rx_mode),
        .tx_rdy        (tx_rdy),
        .ext_rx_en     (ext_rx_en),
        .ext_rx_period (ext_rx_period),
        .ext_tx_en     (ext_tx_en),
        .ext_tx_period (ext_tx_period),
        .sh_en         (sh_en),
        .fsm_rst       (fsm_rst),
        .sh_en_done    (sh_en_done),
        .locked        (locked),
        .period_out    (period_out),
        .err_timeout   (err_timeout),
        .err_jitter    (err_jitter)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sh_en === 1'b1) begin
            sh_q.push_back(cyc);
            if (prev_sh) consec++;
        end
        prev_sh = (sh_en === 1'b1);
        if (err_timeout === 1'b1) tmo_q.push_back(cyc);
        if (err_jitter === 1'b1)  jit_q.push_back(cyc);
        if (fsm_rst === 1'b1)     fsm_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        if (n > 0) #1;
    endtask

    task automatic rf_pulse(input int gap, output int rise);
        rise = cyc;
        rfin = 1'b1;
        tick(3);
        rfin = 1'b0;
        tick(gap - 3);
    endtask

    task automatic rf_train(input int n, input int gap, output int last);
        for (int i = 0; i < n; i++) rf_pulse((i == n - 1) ? 3 : gap, last);
    endtask

    function automatic int q_at(input int idx);
        return (idx < sh_q.size()) ? sh_q[idx] : -1;
    endfunction

    function automatic int bad_spacing(input int sp);
        int bad = 0;
        for (int i = 1; i < sh_q.size(); i++) if (sh_q[i] - sh_q[i-1] != sp) bad++;
        return bad;
    endfunction

    task automatic abort_gen();
        rx_mode = 1'b0;
        tick(2);
        rx_mode = 1'b1;
        tick(2);
    endtask

    initial begin
        int r, r4, t;
        int gaps[12] = '{1000, 1000, 1300, 1200, 1200, 1200, 1200, 1200, 1200, 1200, 1200, 3};

        rst = 1'b0; rfin = 1'b0; rx_mode = 1'b1; tx_rdy = 1'b0;
        ext_rx_en = 1'b0; ext_rx_period = '0; ext_tx_en = 1'b0; ext_tx_period = '0;
        tick(3);
        check("rst_sh_en", sh_en, 0);
        check("rst_fsm_rst", fsm_rst, 0);
        check("rst_done", sh_en_done, 1);
        check("rst_locked", locked, 0);
        check("rst_period", period_out, 0);
        check("rst_errs", {err_timeout, err_jitter}, 0);
        rst = 1'b1;
        tick(2);

        // Nominal lock at 1000-cycle spacing and full 24-strobe packet.
        sh_q.delete(); fsm_cnt = 0;
        rf_train(9, 1000, r);
        tick(2);
        check("rx_locked", locked, 1);
        check("rx_period", period_out, 1000);
        tick(23502);
        check("rx_count", sh_q.size(), 24);
        check("rx_first", q_at(0) - r, 505);
        check("rx_spacing", bad_spacing(1000), 0);
        check("rx_unlock", locked, 0);
        check("rx_fsm_rst", fsm_cnt, 9);

        // Preamble timeout.
        sh_q.delete(); tmo_q.delete(); fsm_cnt = 0;
        rf_train(3, 1000, r);
        tick(14002);
        check("tmo_count", tmo_q.size(), 1);
        check("tmo_time", (tmo_q.size() > 0) ? tmo_q[0] - r : -1, 14003);
        check("tmo_no_sh", sh_q.size(), 0);
        check("tmo_fsm_rst", fsm_cnt, 4);
        check("tmo_locked", locked, 0);

        // Jitter rejection and relock.
        sh_q.delete(); jit_q.delete();
        r4 = 0;
        for (int i = 0; i < 12; i++) begin
            rf_pulse(gaps[i], r);
            if (i == 3) r4 = r;
        end
        tick(2);
        check("jit_count", jit_q.size(), 1);
        check("jit_time", (jit_q.size() > 0) ? jit_q[0] - r4 : -1, 3);
        check("jit_period", period_out, 1200);
        check("jit_locked", locked, 1);
        rx_mode = 1'b0;
        tick(2);
        check("abort_locked", locked, 0);
        check("abort_wait_tx", sh_en_done, 0);
        rx_mode = 1'b1;
        tick(2);
        check("abort_no_sh", sh_q.size(), 0);

        // External RX period override.
        sh_q.delete();
        ext_rx_en = 1'b1; ext_rx_period = 14'd777;
        rf_train(9, 300, r);
        tick(2);
        check("ext_period", period_out, 777);
        tick(1167);
        check("ext_count", sh_q.size(), 2);
        check("ext_first", q_at(0) - r, 393);
        check("ext_spacing", q_at(1) - q_at(0), 777);
        abort_gen();

        // Zero override floors at MIN_PERIOD.
        sh_q.delete();
        ext_rx_period = 14'd0;
        rf_train(9, 100, r);
        tick(2);
        check("min_period", period_out, 2);
        tick(55);
        check("min_count", sh_q.size(), 24);
        check("min_first", q_at(0) - r, 6);
        check("min_spacing", bad_spacing(2), 0);
        check("min_unlock", locked, 0);
        ext_rx_en = 1'b0;

        // Default TX burst start, aborted by rx_mode.
        sh_q.delete();
        rx_mode = 1'b0;
        tick(3);
        check("tx_done_low", sh_en_done, 0);
        tx_rdy = 1'b1; t = cyc;
        tick(5004);
        check("tx_count", sh_q.size(), 1);
        check("tx_first", q_at(0) - t, 5002);
        rx_mode = 1'b1;
        tick(1);
        check("tx_abort_done", sh_en_done, 1);
        tx_rdy = 1'b0;
        tick(2);

        // Full TX burst with external period.
        sh_q.delete();
        ext_tx_en = 1'b1; ext_tx_period = 14'd100;
        rx_mode = 1'b0;
        tick(3);
        tx_rdy = 1'b1; t = cyc;
        tick(3153);
        check("txe_count", sh_q.size(), 32);
        check("txe_first", q_at(0) - t, 52);
        check("txe_spacing", bad_spacing(100), 0);
        check("txe_done_idle", sh_en_done, 1);
        tick(1);
        check("txe_done_wait", sh_en_done, 0);
        tx_rdy = 1'b0; rx_mode = 1'b1; ext_tx_en = 1'b0;
        tick(3);

        // Asynchronous reset mid-GEN, then relock.
        sh_q.delete();
        rf_train(9, 200, r);
        tick(107);
        check("mid_locked", locked, 1);
        check("mid_count", sh_q.size(), 1);
        rst = 1'b0;
        #1;
        check("arst_sh_en", sh_en, 0);
        check("arst_done", sh_en_done, 1);
        check("arst_locked", locked, 0);
        check("arst_period", period_out, 0);
        check("arst_errs", {fsm_rst, err_timeout, err_jitter}, 0);
        rst = 1'b1;
        tick(2);
        sh_q.delete();
        rf_train(9, 300, r);
        tick(2);
        check("relock_period", period_out, 300);
        check("relock_locked", locked, 1);
        tick(152);
        check("relock_count", sh_q.size(), 1);
        check("relock_first", q_at(0) - r, 155);
        abort_gen();

        check("no_consecutive_sh", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
